display_value_latch: RTL
========================

// Module: display_value_latch
// PURPOSE
//  Memory-mapped output port between the processor data bus and the 5-digit signed decimal display stage.
//  - Captures CPU writes into a shadow register.
//  - Forwards the shadow to the display at a throttled refresh rate, so fast-changing values stay readable.
//  - Supports a freeze input and tracks a sticky overflow flag (|value| > 99999).
// PARAMETERS
//  ADDR_W          16            bus address width
//  DISP_ADDR       16'hFF00      value register address; status/control register is at DISP_ADDR+1
//  REFRESH_CYCLES  5_000_000     clk cycles per refresh tick (min 1)
//  BLINK_CYCLES    25_000_000    half-period of overflow blink (DISP_OVF_BLINK_EN only)
// PORTS
//  clk              in   1       system clock
//  rst              in   1       synchronous active-high reset
//  bus_addr         in   ADDR_W  CPU address
//  bus_wdata        in   32      CPU write data
//  bus_we           in   1       write strobe, 1 cycle
//  bus_rd           in   1       read strobe, 1 cycle
//  bus_rdata        out  32      read data, valid the cycle after bus_rd
//  freeze           in   1       level; while high, disp_val is held
//  disp_val         out  32      signed value presented to the decimal display stage
//  disp_valid       out  1       goes high at the first transfer after reset, then stays high
//  pending          out  1       shadow holds a value not yet shown
//  ovf_sticky       out  1       a transferred value had |v| > 99999
//  disp_blank       out  1       blanks the display (blink); 0 when the feature is off
// BEHAVIOUR
//  Reset:
//   - All outputs and registers go to 0; refresh counter 0; state S_IDLE.
//   - A reset mid-operation discards any pending write.
//  Refresh counter:
//   - Counts 0..REFRESH_CYCLES-1 and wraps.
//   - tick=1 when count==REFRESH_CYCLES-1. REFRESH_CYCLES=1 -> tick every cycle.
//  Write to DISP_ADDR:
//   - shadow<=bus_wdata and pending<=1 next edge.
//   - Back-to-back writes: last one wins.
//  FSM states:
//   - S_IDLE (no pending)
//   - S_PEND (pending, waiting for tick)
//   - S_FRZ (freeze high)
//  FSM transitions:
//   - IDLE->PEND on write.
//   - PEND->IDLE on tick with freeze=0: disp_val<=shadow, disp_valid<=1, pending<=0.
//   - Any state->FRZ when freeze=1. Writes still update the shadow and set pending while frozen.
//   - FRZ->PEND when freeze falls with pending=1; FRZ->IDLE otherwise.
//   - Freeze falling on a tick cycle does not transfer; the next tick does.
//  Write and tick in the same cycle (PEND or IDLE, freeze=0):
//   - bus_wdata is forwarded straight to disp_val.
//   - shadow<=bus_wdata; pending ends 0.
//  Overflow check:
//   - mag = v[31] ? -v : v, computed in 33 bits (0x80000000 -> 2^31).
//   - mag > 99999 on a transfer sets ovf_sticky.
//   - Write DISP_ADDR+1 with wdata[0]=1 clears it. If the clear lands on an overflowing transfer cycle, set wins.
//  Reads (1-cycle latency):
//   - DISP_ADDR returns shadow.
//   - DISP_ADDR+1 returns {29'b0, freeze, pending, ovf_sticky}.
//   - Any other address returns 0.
//   - bus_rdata holds its value until the next bus_rd.
//  Latency: write -> disp_val at most REFRESH_CYCLES cycles after the write edge when not frozen.
// CONFIGURATION
//  DISP_OVF_BLINK_EN defined:
//   - While ovf_sticky=1, disp_blank toggles every BLINK_CYCLES cycles, starting at 0.
//   - When ovf_sticky clears, the blink counter and disp_blank go to 0 on the same edge.
//  DISP_OVF_BLINK_EN undefined:
//   - disp_blank is tied to 0 and no blink counter is built.
// TESTING  (REFRESH_CYCLES=4, BLINK_CYCLES=3)
//  - Reset, then write 1234 at cycle 1 -> pending=1; disp_val=1234, disp_valid=1, pending=0 on the cycle after the first tick.
//  - Write 5, 6, 7 between ticks -> only 7 reaches disp_val; read DISP_ADDR returns 7 one cycle after bus_rd.
//  - Write -42 (0xFFFFFFD6) on a tick cycle -> disp_val=0xFFFFFFD6 next edge; ovf_sticky=0.
//  - freeze=1, write 9 -> disp_val unchanged over 3 ticks; status read returns 3'b110.
//    Release freeze -> 9 appears after the next tick.
//  - Write 100000, then 0x80000000 -> ovf_sticky=1 after each transfer.
//    Write 1 to DISP_ADDR+1 -> ovf_sticky=0.
//    With DISP_OVF_BLINK_EN, disp_blank toggles every 3 cycles while overflow is set.
//  - Assert rst with a write pending -> next cycle all outputs 0, state S_IDLE, no later transfer.

Source files
------------

// File: rtl/display_value_latch.sv
// Memory-mapped latch between the CPU bus and the 5-digit signed decimal display, with throttled
// refresh, freeze and sticky overflow. Define DISP_OVF_BLINK_EN to build the overflow blink.
module display_value_latch #(
    parameter int unsigned          ADDR_W         = 16,
    parameter logic [ADDR_W-1:0]    DISP_ADDR      = 16'hFF00,
    parameter int unsigned          REFRESH_CYCLES = 5_000_000,
    parameter int unsigned          BLINK_CYCLES   = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic              bus_we,
    input  logic              bus_rd,
    output logic [31:0]       bus_rdata,
    input  logic              freeze,
    output logic [31:0]       disp_val,
    output logic              disp_valid,
    output logic              pending,
    output logic              ovf_sticky,
    output logic              disp_blank
);

    localparam int unsigned       CNT_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STAT_ADDR = DISP_ADDR + ADDR_W'(1);
    localparam logic [32:0]       MAG_MAX   = 33'd99999;

    typedef enum logic [1:0] {StIdle, StPend, StFrz} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       disp_val_q, disp_val_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              pending_q, pending_d;
    logic              ovf_q, ovf_d;
    logic              tick, wr_val, wr_ctl, xfer;
    logic [31:0]       xfer_val;
    logic [32:0]       xfer_mag;

    assign tick   = (cnt_q == CNT_MAX);
    assign wr_val = bus_we && (bus_addr == DISP_ADDR);
    assign wr_ctl = bus_we && (bus_addr == STAT_ADDR);

    // A write landing on the transfer cycle bypasses the shadow straight to the display.
    assign xfer_val = wr_val ? bus_wdata : shadow_q;
    assign xfer_mag = xfer_val[31] ? -{1'b1, xfer_val} : {1'b0, xfer_val};

    always_comb begin
        state_d    = state_q;
        shadow_d   = wr_val ? bus_wdata : shadow_q;
        pending_d  = pending_q | wr_val;
        disp_val_d = disp_val_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        rdata_d    = rdata_q;
        xfer       = 1'b0;

        unique case (state_q)
            StIdle, StPend: begin
                if (freeze) begin
                    state_d = StFrz;
                end else if (tick && (pending_q || wr_val)) begin
                    xfer    = 1'b1;
                    state_d = StIdle;
                end else if (wr_val) begin
                    state_d = StPend;
                end
            end
            // Leaving freeze never transfers, even on a tick; the next tick does.
            StFrz: begin
                if (!freeze) begin
                    state_d = pending_d ? StPend : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            pending_d  = 1'b0;
            disp_val_d = xfer_val;
            valid_d    = 1'b1;
        end

        if (xfer && (xfer_mag > MAG_MAX)) begin
            ovf_d = 1'b1;
        end else if (wr_ctl && bus_wdata[0]) begin
            ovf_d = 1'b0;
        end

        if (bus_rd) begin
            if (bus_addr == DISP_ADDR) begin
                rdata_d = shadow_q;
            end else if (bus_addr == STAT_ADDR) begin
                rdata_d = {29'b0, freeze, pending_q, ovf_q};
            end else begin
                rdata_d = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shadow_q   <= 32'd0;
            disp_val_q <= 32'd0;
            rdata_q    <= 32'd0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= tick ? '0 : cnt_q + CNT_W'(1);
            shadow_q   <= shadow_d;
            disp_val_q <= disp_val_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign disp_val   = disp_val_q;
    assign disp_valid = valid_q;
    assign pending    = pending_q;
    assign ovf_sticky = ovf_q;

`ifdef DISP_OVF_BLINK_EN
    localparam int unsigned      BLK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

    logic [BLK_W-1:0] blink_cnt_q;
    logic             blank_q;

    // Keyed off ovf_d so a clear zeroes the blink on the same edge.
    always_ff @(posedge clk) begin
        if (rst || !ovf_d) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (ovf_q) begin
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    assign disp_blank = blank_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_CYCLES;
    assign disp_blank       = 1'b0;
`endif

endmodule
